cnnip_mem_reader: RTL and testbench

Burst read engine that drives a `cnnip_mem_if` master port and converts a block of memory words into a valid/ready stream. It sits directly upstream of the CNN datapath and downstream of the block memory. A command (base address, length) starts the burst. Reads are issued one word per cycle under credit control, so any fixed or variable memory read latency is absorbed by an internal FIFO without losing data under backpressure.

---
 rtl/cnnip_mem_if.sv | 16 +
 rtl/cnnip_mem_reader.sv | 125 ++++++++++++
 tb/tb_cnnip_mem_reader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnnip_mem_if.sv
// Single-port block memory bus: registered read request out, data plus valid back
// after the memory's read latency.
interface cnnip_mem_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  en;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  valid;

    modport master (output en, we, addr, din, input dout, valid);
    modport slave  (input en, we, addr, din, output dout, valid);
endinterface

// File: rtl/cnnip_mem_reader.sv
// Burst read engine: issues one read per cycle under credit control and turns the
// returned words into a valid/ready stream through a small return FIFO.
module cnnip_mem_reader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    cnnip_mem_if.master           mem,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   issue_idx;
    logic [ADDR_WIDTH:0]   out_idx;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         fifo_count;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic                  en_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic                  start_go;
    logic                  credit_ok;
    logic                  issue_go;
    logic                  issue_last;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] issue_addr;

    // In-flight reads plus buffered words never exceed the FIFO, so returns always fit.
    assign credit_ok  = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
    assign start_go   = (state == IDLE) && start && (len != '0);
    assign issue_go   = start_go || ((state == ISSUE) && credit_ok);
    assign issue_last = start_go ? (len == ONE) : (issue_idx == len_q - ONE);
    assign issue_addr = start_go ? base_addr : base_q + issue_idx[ADDR_WIDTH-1:0];

    // Returns with nothing outstanding are leftovers from before a reset.
    assign push    = mem.valid && (outstanding != '0);
    assign m_valid = (fifo_count != '0);
    assign pop     = m_valid && m_ready;
    assign m_data  = m_valid ? fifo_mem[rd_ptr] : '0;
    assign m_last  = m_valid && (out_idx == len_q - ONE);

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign mem.en   = en_q;
    assign mem.addr = addr_q;
    assign mem.we   = 1'b0;
    assign mem.din  = '0;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0)      state_nxt = DONE;
                    else if (issue_last) state_nxt = DRAIN;
                    else                 state_nxt = ISSUE;
                end
            end
            ISSUE:   if (credit_ok && issue_last) state_nxt = DRAIN;
            DRAIN:   if (pop && m_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q        <= 1'b0;
            addr_q      <= '0;
            base_q      <= '0;
            len_q       <= '0;
            issue_idx   <= '0;
            out_idx     <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            en_q <= issue_go;
            if (issue_go) addr_q <= issue_addr;
            if (start_go) begin
                base_q    <= base_addr;
                len_q     <= len;
                issue_idx <= ONE;
                out_idx   <= '0;
            end else begin
                if (issue_go) issue_idx <= issue_idx + ONE;
                if (pop)      out_idx   <= out_idx + ONE;
            end
            outstanding <= outstanding + CW'(issue_go) - CW'(push);
            fifo_count  <= fifo_count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mem.dout;
    end
endmodule

// File: tb/tb_cnnip_mem_reader.sv
// Self-checking bench: a latency-L memory responder plus an address/data scoreboard
// built from the burst command, checked every cycle against the reader's outputs.
module tb_cnnip_mem_reader;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] base_addr;
    logic [12:0] len;
    logic        busy;
    logic        done;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_ready;

    cnnip_mem_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) mem_bus ();

    cnnip_mem_reader #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .mem(mem_bus),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] salt;
    int          lat;
    int          rmode;
    int          stall;
    logic [15:0] lfsr;
    logic [11:0] exp_addr [$];
    logic [31:0] exp_data [$];
    int          touch [4096];
    int          issued;
    int          popped;
    logic        done_pending;
    logic        hv [8];
    logic [11:0] ha [8];

    function automatic logic [31:0] memword(input logic [11:0] a);
        return salt ^ (32'h0001_0001 * {20'd0, a}) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_done"},   done, 0);
        chk({tag, "_mvalid"}, m_valid, 0);
        chk({tag, "_mlast"},  m_last, 0);
        chk({tag, "_mdata"},  m_data, 0);
        chk({tag, "_en"},     mem_bus.en, 0);
        chk({tag, "_we"},     mem_bus.we, 0);
        chk({tag, "_addr"},   mem_bus.addr, 0);
        chk({tag, "_din"},    mem_bus.din, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called one delta after an edge; returns #1 into the cycle after start is accepted.
    task automatic launch(input logic [11:0] b, input logic [12:0] n);
        start = 1'b1;
        base_addr = b;
        len = n;
        for (int i = 0; i < int'(n); i++) begin
            exp_addr.push_back(12'(b + 12'(i)));
            exp_data.push_back(memword(12'(b + 12'(i))));
        end
        step();
        start = 1'b0;
        if (n == 0) done_pending = 1'b1;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while ((busy || exp_data.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_in_time"}, n < budget, 1);
        chk({tag, "_drained"}, exp_data.size(), 0);
        step();
    endtask

    // Memory responder, readiness generator and scoreboard compare, all on the falling edge.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        logic        last_pop;
        mem_bus.valid = 1'b0;
        mem_bus.dout  = '0;
        m_ready = 1'b1;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        for (int i = 0; i < 8; i++) begin hv[i] = 1'b0; ha[i] = '0; end
        forever begin
            @(negedge clk);
            for (int i = 7; i > 0; i--) begin hv[i] = hv[i-1]; ha[i] = ha[i-1]; end
            hv[0] = mem_bus.en;
            ha[0] = mem_bus.addr;
            if (hv[lat]) begin
                mem_bus.valid = 1'b1;
                mem_bus.dout  = memword(ha[lat]);
            end else begin
                mem_bus.valid = 1'b0;
                mem_bus.dout  = $urandom;
            end
            case (rmode)
                1: begin
                    if (stall > 0) begin stall--; m_ready = 1'b0; end
                    else m_ready = 1'b1;
                end
                2: begin
                    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                    m_ready = lfsr[0];
                end
                default: m_ready = 1'b1;
            endcase
            if (rst) begin
                exp_addr.delete();
                exp_data.delete();
                issued = 0;
                popped = 0;
                done_pending = 1'b0;
                prev_stall = 1'b0;
            end else begin
                last_pop = 1'b0;
                chk("write_path", {mem_bus.we, mem_bus.din}, 0);
                if (mem_bus.en) begin
                    issued++;
                    touch[mem_bus.addr]++;
                    if (exp_addr.size() == 0) chk("spurious_en", mem_bus.en, 0);
                    else chk("req_addr", mem_bus.addr, exp_addr.pop_front());
                end
                chk("credit", (issued - popped) <= 4, 1);
                if (prev_stall) begin
                    chk("hold_valid", m_valid, 1);
                    chk("hold_data", m_data, prev_data);
                    chk("hold_last", m_last, prev_last);
                end
                if (m_valid) begin
                    if (exp_data.size() == 0) chk("spurious_valid", m_valid, 0);
                    else begin
                        chk("m_last", m_last, exp_data.size() == 1);
                        if (m_ready) begin
                            chk("m_data", m_data, exp_data[0]);
                            if (exp_data.size() == 1) last_pop = 1'b1;
                            void'(exp_data.pop_front());
                            popped++;
                        end
                    end
                end else begin
                    chk("m_last_idle", m_last, 0);
                end
                chk("done", done, done_pending);
                done_pending = last_pop;
                prev_stall = m_valid && !m_ready;
                prev_data = m_data;
                prev_last = m_last;
            end
        end
    end

    initial begin
        int base_issued;
        int bad;
        rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
        salt = '0; lat = 1; rmode = 0; stall = 0;
        issued = 0; popped = 0; done_pending = 1'b0;
        lfsr = 16'hACE1 ^ 16'($urandom);
        if (lfsr == 0) lfsr = 16'h1;
        for (int i = 0; i < 4096; i++) touch[i] = 0;
        repeat (3) step();
        chk_reset("por");
        rst = 1'b0;
        step();

        // Basic burst: hand-computed addresses and first word.
        launch(12'h010, 13'd4);
        chk("basic_busy", busy, 1);
        chk("basic_en", mem_bus.en, 1);
        chk("basic_a0", mem_bus.addr, 12'h010);
        step(); chk("basic_a1", mem_bus.addr, 12'h011);
        step(); chk("basic_a2", mem_bus.addr, 12'h012);
        chk("basic_first_valid", m_valid, 1);
        chk("basic_first_word", m_data, 32'hC0CE_0010);
        step(); chk("basic_a3", mem_bus.addr, 12'h013);
        wait_idle(100, "basic");

        // Backpressure: only FIFO_DEPTH reads go out while the sink stalls.
        lat = 2; salt = $urandom; rmode = 1; stall = 22;
        base_issued = issued;
        launch(12'h200, 13'd16);
        repeat (19) step();
        chk("stall_reads", issued - base_issued, 4);
        wait_idle(300, "bp");
        rmode = 0;

        // Address wrap at the top of memory.
        lat = 1; salt = $urandom;
        launch(12'hFFE, 13'd4);
        chk("wrap_a0", mem_bus.addr, 12'hFFE);
        step(); chk("wrap_a1", mem_bus.addr, 12'hFFF);
        step(); chk("wrap_a2", mem_bus.addr, 12'h000);
        step(); chk("wrap_a3", mem_bus.addr, 12'h001);
        wait_idle(100, "wrap");

        // Empty burst.
        launch(12'h055, 13'd0);
        chk("empty_done", done, 1);
        chk("empty_en", mem_bus.en, 0);
        step();
        chk("empty_busy", busy, 0);
        chk("empty_en2", mem_bus.en, 0);
        step();

        // Start while busy is ignored.
        salt = $urandom;
        launch(12'h300, 13'd8);
        start = 1'b1; base_addr = 12'h123; len = 13'd5;
        step();
        start = 1'b0;
        wait_idle(200, "ignore");

        // Reset with two reads in flight; their late returns must be dropped.
        lat = 2; rmode = 1; stall = 100;
        launch(12'h100, 13'd16);
        step();
        rst = 1'b1;
        step();
        chk_reset("midrst");
        rst = 1'b0; rmode = 0; stall = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("midrst_quiet", m_valid, 0);
        end
        lat = 1; salt = $urandom;
        base_issued = popped;
        launch(12'h040, 13'd3);
        wait_idle(100, "post_rst");
        chk("post_rst_words", popped - base_issued, 3);

        // Random readiness against the scoreboard.
        lat = 3; rmode = 2; salt = $urandom;
        launch(12'h700, 13'd64);
        wait_idle(2000, "lfsr");
        rmode = 0;

        // Full-memory burst touches each address once.
        lat = 1; salt = $urandom;
        for (int i = 0; i < 4096; i++) touch[i] = 0;
        launch(12'h000, 13'd4096);
        wait_idle(20000, "full");
        bad = 0;
        for (int i = 0; i < 4096; i++) if (touch[i] != 1) bad++;
        chk("full_touch", bad, 0);

        // Randomized bursts.
        for (int k = 0; k < 6; k++) begin
            lat = $urandom_range(1, 5);
            rmode = $urandom_range(0, 2);
            stall = $urandom_range(0, 15);
            salt = $urandom;
            launch(12'($urandom), 13'($urandom_range(1, 40)));
            wait_idle(1000, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
